jt12_opsin: RTL and testbench
=============================

# jt12_opsin

Operator output stage of the FM pipeline, directly downstream of the phase generator. Per slot it adds phase modulation (op1 self-feedback or the modulator value from the connection logic) to the 10-bit phase, runs the log-sine / envelope / exponential chain and emits a signed 14-bit operator sample. It also owns the 6-channel op1 feedback history buffer. Pipeline stages VIII–XII, one slot per clock, 24 slots per sample.

## Interface

Parameters:
- none; table widths and slot order are fixed constants (see Structure)

Ports:
- clk  in  1  system clock, one slot per cycle
- rst_n  in  1  reset, asynchronous, active-low
- zero  in  1  high when stage VIII carries slot 0 (ch0 S1)
- phase_VIII  in  10  phase from phase generator, unsigned
- eg_atten_VIII  in  10  envelope attenuation, 0 = loudest, 0x3FF = silent
- mod_VIII  in  14  signed modulator sample from connection logic, ignored on S1 slots
- fb_VIII  in  3  channel feedback level, 0 = off
- op_result_XII  out  14  signed operator sample
- s1_XII  out  1  high when op_result_XII belongs to an S1 slot

## Operation

- Slot counter (5 bit) at VIII: forced to 0 when zero=1, else increments, wrapping 23→0. Slot order: S1 ch0..5 (0–5), S3 (6–11), S2 (12–17), S4 (18–23). Channel = slot mod 6.
- Modulation term (10 bit, wraps mod 1024):
  - non-S1: mod_VIII[10:1]
  - S1, fb=0: 0
  - S1, fb≠0: bits [9:0] of (prev1[ch] + prev2[ch], 15-bit signed sum) arithmetically shifted right by 10−fb
- phase_mod = phase_VIII + mod term, 10-bit wrap.
- Sign = phase_mod[9]; index = phase_mod[8] ? ~phase_mod[7:0] : phase_mod[7:0].
- logsin[i] = round(−log2(sin((2i+1)π/1024))·256), 12-bit, 256 entries.
- t = logsin + {eg_atten,2'b00}, 13-bit, saturating at 8191.
- exp_rom[j] = round(2^(j/256)·1024) − 1024, 10-bit, 256 entries.
- mag = ({1'b1, exp_rom[~t[7:0]]} << 2) >> t[12:8]; shift ≥13 gives 0. 13-bit magnitude.
- op_result = sign ? −mag : +mag; −0 outputs 0.
- Feedback buffer: per channel prev1, prev2 (14-bit signed). When an S1 result is produced at XII: prev2 ← prev1, prev1 ← result. No other slot writes.
- Reset: op_result_XII=0, s1_XII=0, slot counter=0, all prev1/prev2=0, pipeline registers 0.

## Timing

- Latency: inputs at VIII → op_result_XII 4 clocks later (registers at IX, X, XI, XII).
- Throughput: one slot per clock, no stalls, no handshake.
- Feedback read for channel c at VIII uses prev values written by the S1 result of c from the previous sample (24 cycles earlier); write at XII and read of the same channel never coincide in one cycle (write slot c at XII reads slot c+4 at VIII).
- zero asserted off-sequence: counter realigns immediately; in-flight slots retain their already-latched S1 tag.
- rst_n asserted mid-operation: all state clears asynchronously; first output after release is 0 until valid data reaches XII.

## Structure

- Shared package: slot-order constants (S1/S3/S2/S4 base 0/6/12/18), NUM_SLOTS=24, NUM_CH=6, table widths (12, 10), output width 14.
- One sub-module natural: jt12_opsin_rom, holding logsin and exp tables as two 256-entry registered ROMs (1-cycle read), instanced once.
- Feedback buffer as 12×14-bit register array inside the top.

## Test plan

- phase_VIII=0x100, atten=0, mod=0, non-S1 slot → op_result_XII=+8168 four clocks later; phase=0x300 → −8168.
- phase=0x100, atten=0x020 → +5776; atten=0x3FF → 0.
- S1 slot, fb=0, mod_VIII=0x1FFF → modulation ignored, output equals unmodulated value.
- Non-S1 slot, phase=0x000, mod_VIII=0x0200 (term 0x100) → +8168.
- Ch2 S1, fb=7, drive phase so two consecutive samples give prev1=prev2=+8168 → next sample's mod term = 16336>>>3 = 2042 → low 10 bits 0x3FA added to phase; check buffer untouched by S2/S3/S4 slots.
- Pulse zero at slot 10 and assert rst_n low mid-stream → counter restarts at 0, s1_XII follows new alignment; reset clears output and feedback (next S1 with fb=7 has term 0).

Source files
------------

// File: rtl/jt12_opsin_pkg.sv
// Shared constants, slot tag type and ROM content generators for the
// jt12 operator output stage.
package jt12_opsin_pkg;

  localparam int NUM_SLOTS = 24;
  localparam int NUM_CH    = 6;

  // Slot order within one sample: S1, S3, S2, S4, six channels each.
  localparam int S1_BASE = 0;
  localparam int S3_BASE = 6;
  localparam int S2_BASE = 12;
  localparam int S4_BASE = 18;

  localparam int LOGSIN_W = 12;
  localparam int EXP_W    = 10;
  localparam int T_W      = 13;
  localparam int OUT_W    = 14;

  localparam real PI = 3.14159265358979323846;

  // Per-slot information that travels down the pipeline next to the data.
  typedef struct packed {
    logic       vld;
    logic       sgn;
    logic       s1;
    logic [2:0] ch;
  } slot_tag_t;

  // -log2(sin((2i+1)*pi/1024)) in 4.8 fixed point, rounded.
  function automatic logic [LOGSIN_W-1:0] logsin_val(input int idx);
    real x;
    real v;
    x = (2.0 * real'(idx) + 1.0) * PI / 1024.0;
    v = -($ln($sin(x)) / $ln(2.0)) * 256.0;
    return LOGSIN_W'($rtoi(v + 0.5));
  endfunction

  // Fractional part of 2^(i/256) scaled by 1024, rounded; implicit leading one.
  function automatic logic [EXP_W-1:0] exp_val(input int idx);
    real v;
    v = $pow(2.0, real'(idx) / 256.0) * 1024.0;
    return EXP_W'($rtoi(v + 0.5) - 1024);
  endfunction

  // Channel number (0..5) of a slot in the S1/S3/S2/S4 ordering.
  function automatic logic [2:0] slot_channel(input logic [4:0] slot);
    logic [2:0] ch;
    if (slot >= 5'(S4_BASE)) begin
      ch = 3'(slot - 5'(S4_BASE));
    end else if (slot >= 5'(S2_BASE)) begin
      ch = 3'(slot - 5'(S2_BASE));
    end else if (slot >= 5'(S3_BASE)) begin
      ch = 3'(slot - 5'(S3_BASE));
    end else begin
      ch = 3'(slot - 5'(S1_BASE));
    end
    return ch;
  endfunction

endpackage

// File: rtl/jt12_opsin_rom.sv
// Log-sine and exponential lookup tables, each a 256-entry ROM with a
// registered (one clock) read port.
module jt12_opsin_rom
  import jt12_opsin_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          ls_addr_i,
  input  logic [7:0]          ex_addr_i,
  output logic [LOGSIN_W-1:0] ls_data_o,
  output logic [EXP_W-1:0]    ex_data_o
);

  logic [LOGSIN_W-1:0] ls_tab_s [256];
  logic [EXP_W-1:0]    ex_tab_s [256];
  logic [LOGSIN_W-1:0] ls_q;
  logic [EXP_W-1:0]    ex_q;

  // Table contents are constants computed at elaboration.
  for (genvar g = 0; g < 256; g++) begin : g_tab
    assign ls_tab_s[g] = logsin_val(g);
    assign ex_tab_s[g] = exp_val(g);
  end

  // Registered table reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_q <= '0;
      ex_q <= '0;
    end else begin
      ls_q <= ls_tab_s[ls_addr_i];
      ex_q <= ex_tab_s[ex_addr_i];
    end
  end

  assign ls_data_o = ls_q;
  assign ex_data_o = ex_q;

endmodule

// File: rtl/jt12_opsin.sv
// Operator output stage: phase modulation, log-sine, envelope add,
// exponential and sign, stages VIII..XII, plus the op1 feedback history.
module jt12_opsin
  import jt12_opsin_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             zero,
  input  logic [9:0]       phase_VIII,
  input  logic [9:0]       eg_atten_VIII,
  input  logic [13:0]      mod_VIII,
  input  logic [2:0]       fb_VIII,
  output logic [OUT_W-1:0] op_result_XII,
  output logic             s1_XII
);

  // ---------------- stage VIII: slot tracking and phase modulation --------
  logic [4:0]        slot_q;
  logic [4:0]        slot_d;
  logic              s1_s;
  logic [2:0]        ch_s;
  logic signed [13:0] fb_p1_s;
  logic signed [13:0] fb_p2_s;
  logic signed [14:0] fb_sum_s;
  logic signed [14:0] fb_shift_s;
  logic [3:0]        fb_shamt_s;
  logic [9:0]        mod_term_s;
  logic [9:0]        phase_mod_s;
  logic [7:0]        idx_s;

  // op1 history: entries 0..5 hold prev1 per channel, 6..11 hold prev2.
  logic signed [13:0] fb_buf_q [2*NUM_CH];

  // Slot counter realigns on zero, otherwise steps 0..23 and wraps.
  always_comb begin
    slot_d = 5'd0;
    if (zero) begin
      slot_d = 5'd0;
    end else if (slot_q == 5'(NUM_SLOTS - 1)) begin
      slot_d = 5'd0;
    end else begin
      slot_d = slot_q + 5'd1;
    end
  end

  // Slot counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= 5'd0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Feedback (S1) or modulator term, then modulated phase and table index.
  always_comb begin
    s1_s       = (slot_d < 5'(S3_BASE));
    ch_s       = slot_channel(slot_d);
    fb_p1_s    = fb_buf_q[4'(ch_s)];
    fb_p2_s    = fb_buf_q[4'(ch_s) + 4'(NUM_CH)];
    fb_sum_s   = {fb_p1_s[13], fb_p1_s} + {fb_p2_s[13], fb_p2_s};
    fb_shamt_s = 4'd10 - {1'b0, fb_VIII};
    fb_shift_s = fb_sum_s >>> fb_shamt_s;
    if (!s1_s) begin
      mod_term_s = mod_VIII[10:1];
    end else if (fb_VIII == 3'd0) begin
      mod_term_s = 10'd0;
    end else begin
      mod_term_s = fb_shift_s[9:0];
    end
    phase_mod_s = phase_VIII + mod_term_s;
    if (phase_mod_s[8]) begin
      idx_s = ~phase_mod_s[7:0];
    end else begin
      idx_s = phase_mod_s[7:0];
    end
  end

  // Bits of the inputs and intermediates that this stage never consumes.
  logic unused_bits_s;
  assign unused_bits_s = ^{mod_VIII[13:11], mod_VIII[0], fb_shift_s[14:10]};

  // ---------------- ROMs ---------------------------------------------------
  logic [LOGSIN_W-1:0] ls_data_s;
  logic [EXP_W-1:0]    ex_data_s;
  logic [7:0]          ex_addr_s;
  logic [T_W-1:0]      t_x_q;

  // The exp table is read with the inverted fractional attenuation.
  assign ex_addr_s = ~t_x_q[7:0];

  jt12_opsin_rom u_rom (
    .clk       (clk),
    .rst_n     (rst_n),
    .ls_addr_i (idx_s),
    .ex_addr_i (ex_addr_s),
    .ls_data_o (ls_data_s),
    .ex_data_o (ex_data_s)
  );

  // ---------------- stage IX: log-sine valid, add envelope ----------------
  slot_tag_t   tag_ix_q;
  logic [9:0]  atten_ix_q;
  logic [13:0] t_sum_s;
  logic [T_W-1:0] t_s;

  // Stage IX tag and attenuation, aligned with the log-sine ROM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_ix_q   <= '0;
      atten_ix_q <= 10'd0;
    end else begin
      tag_ix_q   <= '{vld: 1'b1, sgn: phase_mod_s[9], s1: s1_s, ch: ch_s};
      atten_ix_q <= eg_atten_VIII;
    end
  end

  // Total attenuation in the log domain, saturating at the 13-bit maximum.
  always_comb begin
    t_sum_s = {2'b00, ls_data_s} + {2'b00, atten_ix_q, 2'b00};
    if (t_sum_s[13]) begin
      t_s = 13'h1FFF;
    end else begin
      t_s = t_sum_s[12:0];
    end
  end

  // ---------------- stage X: attenuation registered, exp ROM addressed ----
  slot_tag_t tag_x_q;

  // Stage X registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_x_q   <= 13'd0;
      tag_x_q <= '0;
    end else begin
      t_x_q   <= t_s;
      tag_x_q <= tag_ix_q;
    end
  end

  // ---------------- stage XI: exp value valid, shift and sign -------------
  slot_tag_t      tag_xi_q;
  logic [4:0]     shift_xi_q;
  logic [12:0]    mag_base_s;
  logic [12:0]    mag_s;
  logic [OUT_W-1:0] res_s;

  // Stage XI registers: integer part of the attenuation becomes the shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_xi_q <= 5'd0;
      tag_xi_q   <= '0;
    end else begin
      shift_xi_q <= t_x_q[12:8];
      tag_xi_q   <= tag_x_q;
    end
  end

  // Linear magnitude from the exp table, then apply the half-wave sign.
  always_comb begin
    mag_base_s = {1'b1, ex_data_s, 2'b00};
    if (shift_xi_q >= 5'd13) begin
      mag_s = 13'd0;
    end else begin
      mag_s = mag_base_s >> shift_xi_q;
    end
    if (!tag_xi_q.vld) begin
      res_s = 14'd0;
    end else if (tag_xi_q.sgn) begin
      res_s = 14'd0 - {1'b0, mag_s};
    end else begin
      res_s = {1'b0, mag_s};
    end
  end

  // ---------------- stage XII: outputs and feedback history ---------------
  logic [OUT_W-1:0] op_result_q;
  logic             s1_q;

  // Registered operator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_result_q <= 14'd0;
      s1_q        <= 1'b0;
    end else begin
      op_result_q <= res_s;
      s1_q        <= tag_xi_q.vld & tag_xi_q.s1;
    end
  end

  // S1 results shift into the channel's history: prev2 <= prev1 <= result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2 * NUM_CH; i++) begin
        fb_buf_q[i] <= 14'sd0;
      end
    end else if (tag_xi_q.vld && tag_xi_q.s1) begin
      fb_buf_q[4'(tag_xi_q.ch) + 4'(NUM_CH)] <= fb_buf_q[4'(tag_xi_q.ch)];
      fb_buf_q[4'(tag_xi_q.ch)]              <= res_s;
    end else begin
      fb_buf_q <= fb_buf_q;
    end
  end

  assign op_result_XII = op_result_q;
  assign s1_XII        = s1_q;

endmodule

// File: tb/tb_jt12_opsin.sv
// Scoreboard bench for jt12_opsin: stimulus pushes model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_jt12_opsin;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        zero = 1'b0;
  logic [9:0]  phase_VIII = 10'd0;
  logic [9:0]  eg_atten_VIII = 10'd0;
  logic [13:0] mod_VIII = 14'd0;
  logic [2:0]  fb_VIII = 3'd0;
  logic [13:0] op_result_XII;
  logic        s1_XII;

  jt12_opsin dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .zero          (zero),
    .phase_VIII    (phase_VIII),
    .eg_atten_VIII (eg_atten_VIII),
    .mod_VIII      (mod_VIII),
    .fb_VIII       (fb_VIII),
    .op_result_XII (op_result_XII),
    .s1_XII        (s1_XII)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int res;
    bit s1;
    int due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state
  int ls_tab[256];
  int ex_tab[256];
  int m_slot = 0;
  int m_p1[6];
  int m_p2[6];

  // Operator output computed from the arithmetic description.
  function automatic int model_out(int ph, int att, int modv, int fbv, int slot);
    int ch, term, pm, sg, q, idx, t, sh, mag, r;
    bit s1;
    ch = slot % 6;
    s1 = (slot < 6);
    if (!s1) term = (modv >> 1) & 1023;
    else if (fbv == 0) term = 0;
    else term = ((m_p1[ch] + m_p2[ch]) >>> (10 - fbv)) & 1023;
    pm  = (ph + term) % 1024;
    sg  = pm / 512;
    q   = pm % 512;
    idx = (q >= 256) ? (511 - q) : q;
    t   = ls_tab[idx] + att * 4;
    if (t > 8191) t = 8191;
    sh  = t / 256;
    mag = (sh >= 13) ? 0 : (((1024 + ex_tab[255 - (t % 256)]) * 4) >> sh);
    r   = sg ? -mag : mag;
    if (s1) begin
      m_p2[ch] = m_p1[ch];
      m_p1[ch] = r;
    end
    return r;
  endfunction

  // Drive one slot (called at negedge+1), push its expectation, advance.
  task automatic issue(input bit z, input int ph, input int att, input int modv,
                       input int fbv, input bit use_want, input int want);
    int   r;
    exp_t e;
    if (z) m_slot = 0;
    else m_slot = (m_slot + 1) % 24;
    r     = model_out(ph, att, modv, fbv, m_slot);
    e.res = use_want ? want : r;
    e.s1  = (m_slot < 6);
    e.due = cyc + 4;
    sb.push_back(e);
    zero          = z;
    phase_VIII    = 10'(ph);
    eg_atten_VIII = 10'(att);
    mod_VIII      = 14'(modv);
    fb_VIII       = 3'(fbv);
    @(negedge clk);
    #1;
  endtask

  task automatic issue_rand(input bit z);
    int att;
    att = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 200);
    issue(z, $urandom_range(0, 1023), att, $urandom_range(0, 16383), $urandom_range(0, 7), 1'b0, 0);
  endtask

  // Hold reset n cycles; outputs must read 0 during reset and pipeline refill.
  task automatic do_reset(input int n);
    exp_t e;
    int   c;
    rst_n = 1'b0;
    sb.delete();
    c = cyc;
    for (int k = 1; k <= n; k++) begin
      e.res = 0; e.s1 = 1'b0; e.due = c + k;
      sb.push_back(e);
    end
    repeat (n) begin
      @(negedge clk);
      #1;
    end
    rst_n  = 1'b1;
    m_slot = 0;
    for (int i = 0; i < 6; i++) begin
      m_p1[i] = 0;
      m_p2[i] = 0;
    end
    for (int k = 1; k <= 3; k++) begin
      e.res = 0; e.s1 = 1'b0; e.due = cyc + k;
      sb.push_back(e);
    end
  endtask

  // Monitor: compare every expectation that falls due at this negedge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      total = total + 2;
      if (e.due != cyc || op_result_XII !== 14'(e.res)) begin
        bad = bad + 1;
        $display("FAIL op_result cyc=%0d due=%0d got=%0d want=%0d",
                 cyc, e.due, $signed(op_result_XII), e.res);
      end
      if (s1_XII !== e.s1) begin
        bad = bad + 1;
        $display("FAIL s1_tag cyc=%0d got=%0b want=%0b", cyc, s1_XII, e.s1);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      real x;
      real v;
      x = (2.0 * real'(i) + 1.0) * 3.14159265358979323846 / 1024.0;
      v = -($ln($sin(x)) / $ln(2.0)) * 256.0;
      ls_tab[i] = $rtoi(v + 0.5);
      v = $pow(2.0, real'(i) / 256.0) * 1024.0;
      ex_tab[i] = $rtoi(v + 0.5) - 1024;
    end

    @(negedge clk);
    #1;
    do_reset(3);

    // Directed sample: plain sine peaks, envelope, silence, modulator path.
    for (int s = 0; s < 24; s++) begin
      case (s)
        0:  issue(1'b1, 'h100, 0,     'h1FFF, 0, 1'b1, 8168);
        6:  issue(1'b0, 'h100, 0,     0,      3, 1'b1, 8168);
        7:  issue(1'b0, 'h300, 0,     0,      0, 1'b1, -8168);
        8:  issue(1'b0, 'h100, 'h020, 0,      0, 1'b1, 5776);
        9:  issue(1'b0, 'h100, 'h3FF, 0,      0, 1'b1, 0);
        10: issue(1'b0, 'h000, 0,     'h0200, 5, 1'b1, 8168);
        default: issue_rand(1'b0);
      endcase
    end

    // Channel 2 self-feedback: two peaks, then fb=7 adds 0x3FA to the phase.
    for (int smp = 0; smp < 3; smp++) begin
      for (int s = 0; s < 24; s++) begin
        if (s == 2 && smp < 2) issue(1'b0, 'h100, 0, $urandom_range(0, 16383), 0, 1'b1, 8168);
        else if (s == 2) issue(1'b0, 'h106, 0, $urandom_range(0, 16383), 7, 1'b1, 8168);
        else issue_rand(s == 0);
      end
    end

    // Random samples against the model.
    for (int smp = 0; smp < 12; smp++) begin
      for (int s = 0; s < 24; s++) issue_rand(s == 0);
    end

    // Off-sequence zero at slot 10.
    while (m_slot != 9) issue_rand(1'b0);
    issue_rand(1'b1);
    repeat (30) issue_rand(1'b0);

    // Mid-stream reset; history must be cleared (fb=7 sees a zero term).
    do_reset(2);
    for (int s = 0; s < 24; s++) begin
      if (s == 0) issue(1'b1, 'h100, 0, $urandom_range(0, 16383), 7, 1'b1, 8168);
      else issue_rand(1'b0);
    end
    for (int s = 0; s < 24; s++) issue_rand(s == 0);

    repeat (8) begin
      @(negedge clk);
      #1;
    end
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
